led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
- Consumes the slow step clock produced by the 100 MHz → 1 Hz divider and drives the board LED bank.
- clk_sys is treated as data, not as a clock: synchronised into the 100 MHz domain, rising-edge detected, and each edge advances one of four selectable LED patterns.
- All logic runs on clk.

Parameters:
LED_W, 8, number of LEDs driven; must be ≥ 2.
SYNC_STAGES, 2, flip-flop depth of the clk_sys synchroniser; must be ≥ 2.

Ports:
clk  input  1  100 MHz system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
clk_sys  input  1  slow step clock from the divider; sampled as asynchronous data.
en  input  1  pattern enable; 0 forces the LEDs dark.
mode  input  2  pattern select: 00 SHIFT, 01 BOUNCE, 10 BLINK, 11 FILL.
led  output  LED_W  LED drive, bit 0 = rightmost LED; registered.
step  output  1  one-clk pulse, high in the cycle a new led value first appears.
dir  output  1  BOUNCE direction: 1 = moving right; 0 at all other times; registered.

Behaviour:
Reset (rst_n low, asynchronous):
- led=0, step=0, dir=0, state=IDLE, all synchroniser and edge flops=0.

Synchroniser and edge detect:
- clk_sys passes through SYNC_STAGES flops, then one delay flop.
- tick = last sync flop & ~delay flop.
- Latency (SYNC_STAGES=2): if clk_sys is first sampled high at edge N, led/step update at edge N+2.
- Exactly one tick per clk_sys rising edge, regardless of clk_sys high time.
- If clk_sys is high when rst_n releases, one tick is generated. This is defined behaviour, not an error.

States: IDLE, SHIFT, BOUNCE, BLINK, FILL.
- IDLE: led=0. On tick with en=1, go to the state selected by mode and load that pattern's initial value.
- en=0, any state: at the next clk edge go to IDLE, led=0, dir=0, no tick required. en=0 overrides a coincident tick; step stays 0.
- Mode change: mode is sampled only on a tick. If the sampled mode differs from the current pattern state, that tick loads the new pattern's initial value instead of advancing. Changes between ticks are invisible.
- step=1 on every tick accepted with en=1, including IDLE exit and mode reload; 0 otherwise.

Patterns (values given for LED_W=8; generalise by width):
- SHIFT: init 0x01; rotate left each tick. 0x80 → 0x01 wrap. Period LED_W.
- BOUNCE: init 0x01, dir=0. dir=0 shifts left; on reaching 0x80 set dir=1. dir=1 shifts right; on reaching 0x01 set dir=0. dir updates in the same cycle the end value is loaded. Sequence 01,02,…,80,40,…,01,02. Period 2·LED_W−2.
- BLINK: init 0xFF; toggles 0xFF/0x00 each tick. Period 2.
- FILL: init 0x01; next=(led<<1)|1 until 0xFF, then 0x00, then 0x01. Period LED_W+1.

Outputs and constraints:
- All outputs are registered; no combinational path from inputs to outputs.
- led never holds a value outside the active pattern's sequence.

Test Plan:
- Reset: assert rst_n=0 mid-BOUNCE with led=0x20, dir=1 → led=0x00, dir=0, step=0 immediately, with no clk edge required.
- SHIFT: en=1, mode=00, 10 clk_sys pulses (high 20 clk each) → led 01,02,04,08,10,20,40,80,01,02. step is high exactly 10 cycles, each exactly 2 clk edges after clk_sys is first sampled high.
- BOUNCE: mode=01, 16 pulses → 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02. dir=1 from the 0x80 step through the 0x02 step, 0 otherwise.
- FILL then BLINK: mode=11, 10 pulses → 01,03,07,0F,1F,3F,7F,FF,00,01. Switch mode to 10 between ticks; next tick → 0xFF (reload), following tick → 0x00.
- en handling: drop en mid-SHIFT at led=0x08 → led=0x00 at the next clk with no tick. Drop en in the same cycle as a tick → led=0x00, step=0. Raise en again → led unchanged until the next tick, then 0x01.
- Sync edge cases: clk_sys high for only 1 clk → exactly one tick. clk_sys held high across rst_n release → one tick, led=0x01 if en=1, mode=00. clk_sys held high for 1000 clk → no further ticks.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: the slow divider output is synchronised as data, its rising
// edges step one of four LED patterns (SHIFT, BOUNCE, BLINK, FILL).
module led_pattern_ctrl #(
  parameter int LED_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_sys,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             step,
  output logic             dir
);

  typedef enum logic [2:0] {IDLE, SHIFT, BOUNCE, BLINK, FILL} state_t;

  localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [LED_W-1:0] LED_ALL = {LED_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   tick;

  state_t                 state_q;
  logic [LED_W-1:0]       led_q;
  logic                   step_q;
  logic                   dir_q;

  state_t                 sel_st;
  logic [LED_W-1:0]       init_led;
  logic [LED_W-1:0]       led_d;
  logic                   dir_d;
  logic [LED_W-1:0]       shl;
  logic [LED_W-1:0]       shr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_sys};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // One tick per rising edge of the synchronised step clock, however long it stays high.
  assign tick = sync_q[SYNC_STAGES-1] & ~dly_q;

  always_comb begin
    sel_st   = SHIFT;
    init_led = LED_ONE;
    case (mode)
      2'b00: sel_st = SHIFT;
      2'b01: sel_st = BOUNCE;
      2'b10: begin
        sel_st   = BLINK;
        init_led = LED_ALL;
      end
      default: sel_st = FILL;
    endcase
  end

  assign shl = {led_q[LED_W-2:0], 1'b0};
  assign shr = {1'b0, led_q[LED_W-1:1]};

  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    case (state_q)
      SHIFT:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
      BOUNCE: begin
        // Direction flips in the same cycle the end LED is loaded.
        if (!dir_q) begin
          led_d = shl;
          dir_d = (shl == LED_MSB);
        end else begin
          led_d = shr;
          dir_d = (shr != LED_ONE);
        end
      end
      BLINK:  led_d = ~led_q;
      FILL:   led_d = (led_q == LED_ALL) ? '0 : (shl | LED_ONE);
      default: begin
        led_d = '0;
        dir_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      led_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        led_q   <= '0;
        dir_q   <= 1'b0;
      end else if (tick) begin
        step_q <= 1'b1;
        // A tick whose sampled mode differs from the running pattern restarts it.
        if (state_q != sel_st) begin
          state_q <= sel_st;
          led_q   <= init_led;
          dir_q   <= 1'b0;
        end else begin
          led_q <= led_d;
          dir_q <= dir_d;
        end
      end
    end
  end

  assign led  = led_q;
  assign step = step_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: each driven clk_sys pulse queues the expected
// LED/dir value and arrival cycle; the monitor pops and compares on every step pulse.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_sys = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] led;
  logic       step;
  logic       dir;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] led;
    logic       dir;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  led_pattern_ctrl #(.LED_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_sys(clk_sys), .en(en), .mode(mode),
    .led(led), .step(step), .dir(dir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Any step is a DUT output event; it must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && step) begin
      if (sb.size() == 0) chk("spurious_step", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("led", {24'd0, led}, {24'd0, e.led});
        chk("dir", {31'd0, dir}, {31'd0, e.dir});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Raise clk_sys just after a negedge: first sampled on the next posedge,
  // result visible two posedges later.
  task automatic pulse(input int hi, input logic [7:0] l, input logic d);
    exp_t e;
    @(negedge clk);
    clk_sys = 1'b1;
    e.led = l; e.dir = d; e.cyc = cyc + 3;
    sb.push_back(e);
    repeat (hi) @(negedge clk);
    clk_sys = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  logic [7:0] shift_seq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] bnc_seq [16]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic       bnc_dir [16]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] fill_seq [10]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_led", {24'd0, led}, 32'h0);
    chk("rst_step", {31'd0, step}, 32'h0);
    chk("rst_dir", {31'd0, dir}, 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (4) @(negedge clk);

    mode = 2'b00;
    for (int i = 0; i < 10; i++) pulse(20, shift_seq[i], 1'b0);
    mode = 2'b01;
    for (int i = 0; i < 16; i++) pulse(20, bnc_seq[i], bnc_dir[i]);
    mode = 2'b11;
    for (int i = 0; i < 10; i++) pulse(20, fill_seq[i], 1'b0);
    mode = 2'b10;
    pulse(20, 8'hFF, 1'b0);
    pulse(20, 8'h00, 1'b0);

    // en dropped mid-SHIFT clears without a tick
    mode = 2'b00;
    pulse(20, 8'h01, 1'b0);
    pulse(20, 8'h02, 1'b0);
    pulse(20, 8'h04, 1'b0);
    pulse(20, 8'h08, 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_led", {24'd0, led}, 32'h0);
    chk("en_off_step", {31'd0, step}, 32'h0);
    en = 1'b1;
    repeat (5) @(negedge clk);
    chk("en_on_hold", {24'd0, led}, 32'h0);
    pulse(20, 8'h01, 1'b0);
    pulse(20, 8'h02, 1'b0);

    // en dropped in the very cycle the tick would land
    @(negedge clk);
    clk_sys = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_tick_led", {24'd0, led}, 32'h0);
    chk("en_tick_step", {31'd0, step}, 32'h0);
    repeat (5) @(negedge clk);
    clk_sys = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_tick_hold", {24'd0, led}, 32'h0);

    // narrow and very long clk_sys highs each give one tick
    pulse(1, 8'h01, 1'b0);
    pulse(1000, 8'h02, 1'b0);

    // async reset mid-BOUNCE, then release with clk_sys already high
    mode = 2'b01;
    for (int i = 0; i < 10; i++) pulse(20, bnc_seq[i], bnc_dir[i]);
    chk("pre_rst_dir", {31'd0, dir}, 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", {24'd0, led}, 32'h0);
    chk("arst_dir", {31'd0, dir}, 32'h0);
    chk("arst_step", {31'd0, step}, 32'h0);
    clk_sys = 1'b1;
    mode = 2'b00;
    repeat (3) @(negedge clk);
    begin
      exp_t e;
      e.led = 8'h01; e.dir = 1'b0; e.cyc = cyc + 3;
      sb.push_back(e);
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    clk_sys = 1'b0;
    repeat (20) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
